// File: rtl/result_checker.sv
// Checks a (d, c1, c2) sweep: c1 must equal c2, d must walk 0..2^DW-1 once, in order.
// Latency: outputs register one edge after the accepted sample; no backpressure, samples are never stalled.
module result_checker #(
   parameter int DW = 10,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          valid,
   input  logic [DW-1:0] d,
   input  logic          c1,
   input  logic          c2,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW-1:0] err_cnt,
   output logic [DW-1:0] first_err_d,
   output logic          first_err_vld,
   output logic          seq_err,
   output logic [DW:0]   samp_cnt
);

   localparam logic [DW:0]   SWEEP_LEN = {1'b1, {DW{1'b0}}};
   localparam logic [CW-1:0] ERR_MAX   = '1;

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

   state_t        state, state_n;
   logic [DW-1:0] exp_d, exp_d_n;
   logic [CW-1:0] err_cnt_n;
   logic [DW-1:0] first_err_d_n;
   logic          first_err_vld_n;
   logic          seq_err_n;
   logic          pass_n;
   logic [DW:0]   samp_cnt_n;
   logic          accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         exp_d         <= '0;
         err_cnt       <= '0;
         first_err_d   <= '0;
         first_err_vld <= 1'b0;
         seq_err       <= 1'b0;
         pass          <= 1'b0;
         samp_cnt      <= '0;
      end else begin
         state         <= state_n;
         exp_d         <= exp_d_n;
         err_cnt       <= err_cnt_n;
         first_err_d   <= first_err_d_n;
         first_err_vld <= first_err_vld_n;
         seq_err       <= seq_err_n;
         pass          <= pass_n;
         samp_cnt      <= samp_cnt_n;
      end
   end

   always_comb begin
      state_n         = state;
      exp_d_n         = exp_d;
      err_cnt_n       = err_cnt;
      first_err_d_n   = first_err_d;
      first_err_vld_n = first_err_vld;
      seq_err_n       = seq_err;
      pass_n          = pass;
      samp_cnt_n      = samp_cnt;
      accept          = 1'b0;

      // start overrides everything, including a sample presented on the same cycle
      if (start) begin
         state_n         = ARM;
         exp_d_n         = '0;
         err_cnt_n       = '0;
         first_err_d_n   = '0;
         first_err_vld_n = 1'b0;
         seq_err_n       = 1'b0;
         pass_n          = 1'b0;
         samp_cnt_n      = '0;
      end else begin
         unique case (state)
            ARM:     accept = valid && (d == '0);
            RUN:     accept = valid;
            default: accept = 1'b0;
         endcase
      end

      if (accept) begin
         samp_cnt_n = samp_cnt + 1'b1;
         exp_d_n    = d + 1'b1;
         state_n    = RUN;
         // on a skip, resync to the received value rather than flagging every later sample
         if (state == RUN && d != exp_d)
            seq_err_n = 1'b1;
         if (c1 != c2) begin
            if (err_cnt != ERR_MAX)
               err_cnt_n = err_cnt + 1'b1;
            if (!first_err_vld) begin
               first_err_vld_n = 1'b1;
               first_err_d_n   = d;
            end
         end
         if (samp_cnt_n == SWEEP_LEN) begin
            state_n = DONE;
            pass_n  = (err_cnt_n == '0) && !seq_err_n;
         end
      end
   end

   assign busy = (state == ARM) || (state == RUN);
   assign done = (state == DONE);

endmodule
